// File: rtl/mem_ctrl_pkg.sv
// Shared request encodings, controller states and byte helpers for the cache/memory protocol.
package mem_ctrl_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned MASK_W = 4;
  localparam int unsigned RW_W   = 2;
  localparam int unsigned CNT_W  = 3;

  localparam logic [RW_W-1:0] RW_IDLE  = 2'd0;
  localparam logic [RW_W-1:0] RW_READ  = 2'd1;
  localparam logic [RW_W-1:0] RW_WRITE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } state_e;

  // Index of the lowest set enable bit (caller guarantees m != 0).
  function automatic logic [1:0] lowest_set(input logic [MASK_W-1:0] m);
    logic [1:0] k;
    if (m[0])      k = 2'd0;
    else if (m[1]) k = 2'd1;
    else if (m[2]) k = 2'd2;
    else           k = 2'd3;
    return k;
  endfunction

  // Little-endian byte lane k of a word.
  function automatic logic [BYTE_W-1:0] get_byte(input logic [WORD_W-1:0] w, input logic [1:0] k);
    logic [BYTE_W-1:0] b;
    case (k)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Word-request responder that serialises reads/writes onto an external synchronous byte RAM.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned RAM_ADDR_WIDTH = 17
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [RW_W-1:0]           rw_flag,
  input  logic [WORD_W-1:0]         addr,
  input  logic [WORD_W-1:0]         w_data,
  input  logic [MASK_W-1:0]         w_mask,
  output logic [WORD_W-1:0]         r_data,
  output logic                      busy,
  output logic                      done,
  output logic [RAM_ADDR_WIDTH-1:0] ram_addr,
  output logic                      ram_re,
  output logic                      ram_we,
  output logic [BYTE_W-1:0]         ram_wdata,
  input  logic [BYTE_W-1:0]         ram_rdata
);

  localparam int unsigned BASE_W = RAM_ADDR_WIDTH - 2;

  state_e                    r_state, w_state_nx;
  logic [CNT_W-1:0]          r_cnt, w_cnt_nx;
  logic [BASE_W-1:0]         r_base, w_base_nx;
  logic [WORD_W-1:0]         r_wword, w_wword_nx;
  logic [MASK_W-1:0]         r_mask, w_mask_nx;
  logic [23:0]               r_rbuf, w_rbuf_nx;
  logic [WORD_W-1:0]         r_rdata, w_rdata_nx;
  logic                      r_busy;
  logic                      r_done, w_done_nx;
  logic [RAM_ADDR_WIDTH-1:0] r_ram_addr, w_addr_nx;
  logic                      r_ram_re, w_re_nx;
  logic                      r_ram_we, w_we_nx;
  logic [BYTE_W-1:0]         r_ram_wdata, w_wdata_nx;
  logic [1:0]                w_k;
  logic [BASE_W-1:0]         w_req_base;
  logic                      w_unused_addr;

  // High address bits wrap away; low two bits address bytes, not words.
  assign w_req_base    = addr[RAM_ADDR_WIDTH-1:2];
  assign w_unused_addr = ^{addr[WORD_W-1:RAM_ADDR_WIDTH], addr[1:0]};

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_base      <= '0;
      r_wword     <= '0;
      r_mask      <= '0;
      r_rbuf      <= '0;
      r_rdata     <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_re    <= 1'b0;
      r_ram_we    <= 1'b0;
      r_ram_wdata <= '0;
    end else begin
      r_state     <= w_state_nx;
      r_cnt       <= w_cnt_nx;
      r_base      <= w_base_nx;
      r_wword     <= w_wword_nx;
      r_mask      <= w_mask_nx;
      r_rbuf      <= w_rbuf_nx;
      r_rdata     <= w_rdata_nx;
      r_busy      <= (w_state_nx != ST_IDLE);
      r_done      <= w_done_nx;
      r_ram_addr  <= w_addr_nx;
      r_ram_re    <= w_re_nx;
      r_ram_we    <= w_we_nx;
      r_ram_wdata <= w_wdata_nx;
    end
  end

  // Next-state and next-output decode; r_cnt counts edges since acceptance during a read.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_base_nx  = r_base;
    w_wword_nx = r_wword;
    w_mask_nx  = r_mask;
    w_rbuf_nx  = r_rbuf;
    w_rdata_nx = r_rdata;
    w_done_nx  = 1'b0;
    w_addr_nx  = r_ram_addr;
    w_re_nx    = 1'b0;
    w_we_nx    = 1'b0;
    w_wdata_nx = r_ram_wdata;
    w_k        = 2'd0;

    case (r_state)
      ST_IDLE: begin
        if ((rw_flag & RW_READ) != RW_IDLE) begin
          // Read wins when both strobe bits are set.
          w_state_nx = ST_READ;
          w_base_nx  = w_req_base;
          w_cnt_nx   = '0;
          w_re_nx    = 1'b1;
          w_addr_nx  = {w_req_base, 2'd0};
        end else if ((rw_flag & RW_WRITE) != RW_IDLE) begin
          w_state_nx = ST_WRITE;
          w_base_nx  = w_req_base;
          w_wword_nx = w_data;
          w_mask_nx  = '0;
          if (w_mask != '0) begin
            w_k        = lowest_set(w_mask);
            w_we_nx    = 1'b1;
            w_addr_nx  = {w_req_base, w_k};
            w_wdata_nx = get_byte(w_data, w_k);
            w_mask_nx  = w_mask & ~(MASK_W'(1) << w_k);
          end
        end
      end

      ST_READ: begin
        w_cnt_nx = r_cnt + CNT_W'(1);
        if (r_cnt <= CNT_W'(2)) begin
          w_re_nx   = 1'b1;
          w_addr_nx = {r_base, r_cnt[1:0] + 2'd1};
        end
        // Byte k returns in the cycle where r_cnt == k+1.
        case (r_cnt)
          CNT_W'(1): w_rbuf_nx[7:0]   = ram_rdata;
          CNT_W'(2): w_rbuf_nx[15:8]  = ram_rdata;
          CNT_W'(3): w_rbuf_nx[23:16] = ram_rdata;
          CNT_W'(4): begin
            w_rdata_nx = {ram_rdata, r_rbuf};
            w_done_nx  = 1'b1;
            w_state_nx = ST_IDLE;
          end
          default: ;
        endcase
      end

      ST_WRITE: begin
        if (r_mask != '0) begin
          w_k        = lowest_set(r_mask);
          w_we_nx    = 1'b1;
          w_addr_nx  = {r_base, w_k};
          w_wdata_nx = get_byte(r_wword, w_k);
          w_mask_nx  = r_mask & ~(MASK_W'(1) << w_k);
        end else begin
          w_done_nx  = 1'b1;
          w_state_nx = ST_IDLE;
        end
      end

      default: w_state_nx = ST_IDLE;
    endcase
  end

  assign r_data    = r_rdata;
  assign busy      = r_busy;
  assign done      = r_done;
  assign ram_addr  = r_ram_addr;
  assign ram_re    = r_ram_re;
  assign ram_we    = r_ram_we;
  assign ram_wdata = r_ram_wdata;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a behavioural synchronous byte RAM.
module tb_mem_ctrl;

  localparam int unsigned AW = 17;

  logic          clk;
  logic          rst_n;
  logic [1:0]    rw_flag;
  logic [31:0]   addr;
  logic [31:0]   w_data;
  logic [3:0]    w_mask;
  logic [31:0]   r_data;
  logic          busy;
  logic          done;
  logic [AW-1:0] ram_addr;
  logic          ram_re;
  logic          ram_we;
  logic [7:0]    ram_wdata;
  logic [7:0]    ram_rdata;

  logic [7:0]    mem [0:(1<<AW)-1];
  logic          pl_en;
  logic [AW-1:0] pl_addr;
  logic [7:0]    pl_data;

  int n_checks;
  int n_fail;
  int done_cnt;
  int we_cnt;
  int re_cnt;
  int both_cnt;

  mem_ctrl #(.RAM_ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rw_flag   (rw_flag),
    .addr      (addr),
    .w_data    (w_data),
    .w_mask    (w_mask),
    .r_data    (r_data),
    .busy      (busy),
    .done      (done),
    .ram_addr  (ram_addr),
    .ram_re    (ram_re),
    .ram_we    (ram_we),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous byte RAM with a preload port for the bench.
  always @(posedge clk) begin
    if (ram_re) ram_rdata <= mem[ram_addr];
    if (ram_we) mem[ram_addr] <= ram_wdata;
    if (pl_en)  mem[pl_addr] <= pl_data;
  end

  // Event counters observed over the whole run.
  always @(posedge clk) begin
    if (done) done_cnt++;
    if (ram_we) we_cnt++;
    if (ram_re) re_cnt++;
    if (ram_re && ram_we) both_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [31:0] word);
    for (int k = 0; k < 4; k++) begin
      pl_en   = 1'b1;
      pl_addr = a + AW'(k);
      pl_data = word[8*k +: 8];
      step();
    end
    pl_en = 1'b0;
  endtask

  // Present a one-cycle strobe; returns at accept edge + 1.
  task automatic issue(input logic [1:0] rw, input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    rw_flag = rw;
    addr    = a;
    w_data  = d;
    w_mask  = m;
    step();
    rw_flag = 2'd0;
  endtask

  // Count cycles until done, bounded.
  task automatic wait_done(input int start, output int lat);
    lat = start;
    while (!done && lat < 20) begin
      step();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    n_checks++;
    if ({busy, done, ram_re, ram_we} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b expected 0000", {busy, done, ram_re, ram_we});
    end
    n_checks++;
    if ({r_data, ram_addr, ram_wdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: r_data=%h ram_addr=%h ram_wdata=%h expected 0", r_data, ram_addr, ram_wdata);
    end
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_read();
    int lat;
    int re0;
    preload(AW'('h100), 32'h44332211);
    re0 = re_cnt;
    issue(2'd1, 32'h0000_0100, 32'h0, 4'h0);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL read_busy: got %b expected 1", busy);
    end
    wait_done(0, lat);
    n_checks++;
    if (lat != 5) begin
      n_fail++;
      $display("FAIL read_latency: got %0d expected 5", lat);
    end
    n_checks++;
    if (r_data !== 32'h44332211) begin
      n_fail++;
      $display("FAIL read_data: got %h expected 44332211", r_data);
    end
    n_checks++;
    if (busy !== 1'b0 || re_cnt - re0 != 4) begin
      n_fail++;
      $display("FAIL read_strobes: busy=%b re=%0d expected busy 0 re 4", busy, re_cnt - re0);
    end
    // High address bits wrap onto the same RAM word.
    step();
    issue(2'd1, 32'h0002_0101, 32'h0, 4'h0);
    wait_done(0, lat);
    n_checks++;
    if (lat != 5 || r_data !== 32'h44332211) begin
      n_fail++;
      $display("FAIL read_wrap: lat=%0d data=%h expected 5 44332211", lat, r_data);
    end
    step();
  endtask

  task automatic test_write();
    int lat;
    int we0;
    preload(AW'('h200), 32'h04030201);
    we0 = we_cnt;
    issue(2'd2, 32'h0000_0200, 32'hAABBCCDD, 4'b0101);
    wait_done(0, lat);
    n_checks++;
    if (lat != 2 || we_cnt - we0 != 2) begin
      n_fail++;
      $display("FAIL write_timing: lat=%0d we=%0d expected 2 2", lat, we_cnt - we0);
    end
    n_checks++;
    if ({mem['h203], mem['h202], mem['h201], mem['h200]} !== 32'h04BB02DD) begin
      n_fail++;
      $display("FAIL write_bytes: got %h expected 04bb02dd", {mem['h203], mem['h202], mem['h201], mem['h200]});
    end
    n_checks++;
    if (r_data !== 32'h44332211) begin
      n_fail++;
      $display("FAIL write_keeps_rdata: got %h expected 44332211", r_data);
    end
    step();
  endtask

  task automatic test_back_to_back();
    int lat;
    issue(2'd2, 32'h0000_0300, 32'h12345678, 4'hF);
    wait_done(0, lat);
    n_checks++;
    if (lat != 4) begin
      n_fail++;
      $display("FAIL b2b_write_latency: got %0d expected 4", lat);
    end
    // Strobe the read in the done cycle itself.
    issue(2'd1, 32'h0000_0300, 32'h0, 4'h0);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_accept: busy=%b expected 1", busy);
    end
    wait_done(0, lat);
    n_checks++;
    if (lat != 5 || r_data !== 32'h12345678) begin
      n_fail++;
      $display("FAIL b2b_read: lat=%0d data=%h expected 5 12345678", lat, r_data);
    end
    step();
  endtask

  task automatic test_mask0_rw3();
    int lat;
    int we0;
    we0 = we_cnt;
    issue(2'd2, 32'h0000_0400, 32'hDEADBEEF, 4'h0);
    wait_done(0, lat);
    n_checks++;
    if (lat != 1 || we_cnt != we0) begin
      n_fail++;
      $display("FAIL mask0: lat=%0d we=%0d expected 1 0", lat, we_cnt - we0);
    end
    step();
    preload(AW'('h500), 32'hA4A3A2A1);
    we0 = we_cnt;
    issue(2'd3, 32'h0000_0500, 32'hFFFFFFFF, 4'hF);
    wait_done(0, lat);
    n_checks++;
    if (lat != 5 || r_data !== 32'hA4A3A2A1 || we_cnt != we0) begin
      n_fail++;
      $display("FAIL rw3_read: lat=%0d data=%h we=%0d expected 5 a4a3a2a1 0", lat, r_data, we_cnt - we0);
    end
    step();
  endtask

  task automatic test_reset_mid_read();
    int lat;
    int d0;
    issue(2'd1, 32'h0000_0500, 32'h0, 4'h0);
    step();
    d0 = done_cnt;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, ram_re, ram_we, done} !== 4'b0000 || r_data !== 32'h0 || ram_addr !== '0) begin
      n_fail++;
      $display("FAIL abort_outputs: busy=%b re=%b we=%b done=%b data=%h addr=%h expected zeros",
               busy, ram_re, ram_we, done, r_data, ram_addr);
    end
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) step();
    n_checks++;
    if (done_cnt != d0 || r_data !== 32'h0) begin
      n_fail++;
      $display("FAIL abort_no_done: done pulses=%0d data=%h expected 0 0", done_cnt - d0, r_data);
    end
    issue(2'd1, 32'h0000_0100, 32'h0, 4'h0);
    wait_done(0, lat);
    n_checks++;
    if (lat != 5 || r_data !== 32'h44332211) begin
      n_fail++;
      $display("FAIL post_reset_read: lat=%0d data=%h expected 5 44332211", lat, r_data);
    end
    step();
  endtask

  task automatic test_busy_ignore();
    int lat;
    int d0;
    int we0;
    d0  = done_cnt;
    we0 = we_cnt;
    issue(2'd1, 32'h0000_0500, 32'h0, 4'h0);
    rw_flag = 2'd2;
    addr    = 32'h0000_0600;
    w_data  = 32'h99999999;
    w_mask  = 4'hF;
    step();
    step();
    rw_flag = 2'd0;
    wait_done(2, lat);
    n_checks++;
    if (lat != 5 || r_data !== 32'hA4A3A2A1) begin
      n_fail++;
      $display("FAIL busy_read: lat=%0d data=%h expected 5 a4a3a2a1", lat, r_data);
    end
    for (int i = 0; i < 4; i++) step();
    n_checks++;
    if (done_cnt - d0 != 1 || we_cnt != we0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_ignored: done pulses=%0d we=%0d busy=%b expected 1 0 0", done_cnt - d0, we_cnt - we0, busy);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    done_cnt = 0;
    we_cnt   = 0;
    re_cnt   = 0;
    both_cnt = 0;
    rw_flag  = 2'd0;
    addr     = '0;
    w_data   = '0;
    w_mask   = '0;
    pl_en    = 1'b0;
    pl_addr  = '0;
    pl_data  = '0;
    test_reset();
    test_read();
    test_write();
    test_back_to_back();
    test_mask0_rw3();
    test_reset_mid_read();
    test_busy_ignore();
    n_checks++;
    if (both_cnt != 0) begin
      n_fail++;
      $display("FAIL re_we_exclusive: overlapping cycles=%0d expected 0", both_cnt);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 Parameter RAM_ADDR_WIDTH, default 17, byte-address width of external RAM.
REQ-002 clk  in  1  single clock, all state on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 rw_flag  in  2  request strobe: bit0 read, bit1 write, 0 idle.
REQ-005 addr  in  32  word request byte address; bits [1:0] ignored.
REQ-006 w_data  in  32  write word, little-endian bytes.
REQ-007 w_mask  in  4  write byte enables, bit k selects w_data[8k+7:8k].
REQ-008 r_data  out  32  read word, registered.
REQ-009 busy  out  1  high while a request is in service.
REQ-010 done  out  1  one-cycle completion pulse.
REQ-011 ram_addr  out  RAM_ADDR_WIDTH  byte address to external synchronous byte RAM.
REQ-012 ram_re  out  1  byte read strobe; ram_rdata valid the cycle after.
REQ-013 ram_we  out  1  byte write strobe.
REQ-014 ram_wdata  out  8  write byte.
REQ-015 ram_rdata  in  8  read byte, one-cycle latency after ram_re.

Function
REQ-016 mem_ctrl SHALL act as the memory-side responder of the cache request protocol: one-cycle rw_flag strobe in, one-cycle done pulse out.
REQ-017 A request SHALL be accepted at a rising edge when rw_flag != 0 and state is IDLE; addr, w_data, w_mask SHALL be captured at that edge.
REQ-018 rw_flag == 3 SHALL be serviced as a read only.
REQ-019 States: IDLE, READ, WRITE; IDLE->READ/WRITE on acceptance; READ/WRITE->IDLE at the same edge that sets done.
REQ-020 Because state is IDLE in the cycle done is high, a request strobed during that cycle SHALL be accepted (back-to-back, zero bubble).
REQ-021 busy SHALL equal (state != IDLE); rw_flag while busy SHALL be ignored, no side effect.
REQ-022 READ: ram_re asserted four consecutive cycles for bytes k=0..3, ram_addr = {addr[RAM_ADDR_WIDTH-1:2], k}; byte k SHALL land in r_data[8k+7:8k].
REQ-023 READ latency: done high exactly in the 5th cycle after the accepting edge, r_data fully valid that cycle.
REQ-024 r_data SHALL hold its value until the next read completes; writes SHALL not change it.
REQ-025 WRITE: one ram_we cycle per set mask bit, ascending k, unset bytes skipped, no idle cycles between; ram_wdata = w_data[8k+7:8k].
REQ-026 WRITE latency: done high in cycle max(popcount(w_mask),1) after acceptance; w_mask == 0 SHALL issue no ram_we.
REQ-027 Address bits above RAM_ADDR_WIDTH SHALL be truncated (wrap-around), no error.
REQ-028 ram_re and ram_we SHALL never be high in the same cycle, and both SHALL be 0 in IDLE.
REQ-029 done SHALL be high for exactly one cycle per accepted request.

Reset
REQ-030 On rst_n low, immediately: state IDLE, busy 0, done 0, r_data 0, ram_re 0, ram_we 0, ram_addr 0, ram_wdata 0.
REQ-031 Reset mid-request SHALL abort it: no further RAM strobes, no done pulse, partial write bytes already issued remain in RAM.

Structure
REQ-032 Request encodings (RW_READ=1, RW_WRITE=2) and state constants SHALL live in the shared common header, used by the cache and mem_ctrl.
REQ-033 mem_ctrl SHALL be a single module with no sub-modules; the byte RAM (byte_ram) is external and a bench model only.

Verification
REQ-034 Preload RAM 0x100..0x103 = 11,22,33,44; read addr 0x100 -> done 5 cycles later, r_data = 0x44332211.
REQ-035 Write addr 0x200, w_data 0xAABBCCDD, mask 4'b0101 -> two ram_we cycles (0x200=DD, 0x202=BB), done 2 cycles after accept; 0x201/0x203 unchanged.
REQ-036 Read strobed in done cycle of a full-mask write to same word -> accepted with no bubble, returns newly written word.
REQ-037 Write mask 0 -> no ram_we, done 1 cycle after accept; rw_flag=3 -> read behaviour only.
REQ-038 rst_n low at the 2nd byte of a read -> outputs zero immediately, no done; next read after reset correct.
REQ-039 Strobe rw_flag while busy -> ignored, exactly one done for the original request.
